// File: rtl/dict_pkg.sv
// Shared definitions for the dictionary expander: FSM state encoding, size limits
// and the byte-lane mask helpers used when forming output beats.
package dict_pkg;

  localparam int MAX_LEN         = 64;
  localparam int DICT_WORD_BYTES = 16;
  localparam int LIT_MAX_BYTES   = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LIT     = 3'd1,
    REQ     = 3'd2,
    WAIT    = 3'd3,
    EMIT_LO = 3'd4,
    EMIT_HI = 3'd5
  } state_e;

  // Contiguous low-byte mask with n lanes set; n of 8 or more saturates to all lanes.
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[i] = (4'(i) < n);
    end
    return m;
  endfunction

  function automatic logic [3:0] beat_bytes(input logic [7:0] rem);
    return (rem > 8'd8) ? 4'd8 : rem[3:0];
  endfunction

endpackage

// File: rtl/dict_expander.sv
// Expands literal and dictionary-reference tokens into a byte stream, fetching
// dictionary patterns from HBM one 16-byte word at a time.
module dict_expander #(
  parameter int DATA_WIDTH = 64,
  parameter int HBM_WIDTH  = 128,
  parameter int MAX_LEN    = dict_pkg::MAX_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tok_valid,
  output logic                    tok_ready,
  input  logic                    tok_is_match,
  input  logic [31:0]             tok_id,
  input  logic [7:0]              tok_len,
  input  logic [DATA_WIDTH-1:0]   tok_literal,
  output logic                    hbm_rd_valid,
  output logic [31:0]             hbm_rd_addr,
  input  logic                    hbm_rd_rdy,
  input  logic                    hbm_rsp_valid,
  input  logic [HBM_WIDTH-1:0]    hbm_rsp_data,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_len,
  output logic [31:0]             bytes_out
);

  import dict_pkg::*;

  state_e                    r_state;
  logic [31:0]               r_addr;
  logic [7:0]                r_rem;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic [DATA_WIDTH/8-1:0]   r_out_keep;
  logic [3:0]                r_beat_bytes;
  logic [DATA_WIDTH-1:0]     r_hi;
  logic                      r_err_len;
  logic [31:0]               r_bytes_out;

  logic                      w_len_bad;
  logic                      w_beat_fire;
  logic [7:0]                w_rem_next;
  logic [3:0]                w_next_bytes;
  logic [3:0]                w_rsp_bytes;
  logic                      w_unused_id;

  assign w_len_bad = (tok_len == 8'd0) ||
                     (!tok_is_match && (tok_len > 8'(LIT_MAX_BYTES))) ||
                     ( tok_is_match && (tok_len > 8'(MAX_LEN)));

  assign w_beat_fire  = out_valid && out_ready;
  assign w_rem_next   = r_rem - {4'b0000, r_beat_bytes};
  assign w_next_bytes = beat_bytes(w_rem_next);
  assign w_rsp_bytes  = beat_bytes(r_rem);
  assign w_unused_id  = &{1'b0, tok_id[31:24]};

  // Gating with rst_n keeps the token port closed while reset is held.
  assign tok_ready    = rst_n && (r_state == IDLE);
  assign hbm_rd_valid = (r_state == REQ);
  assign hbm_rd_addr  = r_addr;
  assign out_valid    = (r_state == LIT) || (r_state == EMIT_LO) || (r_state == EMIT_HI);
  assign out_data     = r_out_data;
  assign out_keep     = r_out_keep;
  assign err_len      = r_err_len;
  assign bytes_out    = r_bytes_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= 32'd0;
      r_rem        <= 8'd0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_beat_bytes <= 4'd0;
      r_hi         <= '0;
      r_err_len    <= 1'b0;
      r_bytes_out  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tok_valid) begin
            if (w_len_bad) begin
              r_err_len <= 1'b1;
            end else if (tok_is_match) begin
              r_addr  <= {6'b000000, tok_id[23:0], 2'b00};
              r_rem   <= tok_len;
              r_state <= REQ;
            end else begin
              r_out_data   <= tok_literal;
              r_out_keep   <= keep_mask(tok_len[3:0]);
              r_beat_bytes <= tok_len[3:0];
              r_state      <= LIT;
            end
          end
        end
        LIT: begin
          if (out_ready) r_state <= IDLE;
        end
        REQ: begin
          if (hbm_rd_rdy) r_state <= WAIT;
        end
        // Responses outside WAIT are never looked at, so a stale reply cannot leak out.
        WAIT: begin
          if (hbm_rsp_valid) begin
            r_out_data   <= hbm_rsp_data[DATA_WIDTH-1:0];
            r_hi         <= hbm_rsp_data[HBM_WIDTH-1:DATA_WIDTH];
            r_beat_bytes <= w_rsp_bytes;
            r_out_keep   <= keep_mask(w_rsp_bytes);
            r_state      <= EMIT_LO;
          end
        end
        EMIT_LO: begin
          if (out_ready) begin
            r_rem <= w_rem_next;
            if (w_rem_next == 8'd0) begin
              r_state <= IDLE;
            end else begin
              r_out_data   <= r_hi;
              r_beat_bytes <= w_next_bytes;
              r_out_keep   <= keep_mask(w_next_bytes);
              r_state      <= EMIT_HI;
            end
          end
        end
        EMIT_HI: begin
          if (out_ready) begin
            r_rem <= w_rem_next;
            if (w_rem_next == 8'd0) begin
              r_state <= IDLE;
            end else begin
              r_addr  <= r_addr + 32'd1;
              r_state <= REQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_beat_fire) r_bytes_out <= r_bytes_out + 32'(r_beat_bytes);
    end
  end

endmodule

// File: tb/tb_dict_expander.sv
// Scoreboard bench for dict_expander: expected beats and reads are queued as tokens
// are driven, a negedge monitor collects what the DUT produced, and each test compares.
module tb_dict_expander;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic         tok_is_match = 1'b0;
  logic [31:0]  tok_id = 32'd0;
  logic [7:0]   tok_len = 8'd0;
  logic [63:0]  tok_literal = 64'd0;
  logic         hbm_rd_valid;
  logic [31:0]  hbm_rd_addr;
  logic         hbm_rd_rdy = 1'b1;
  logic         hbm_rsp_valid;
  logic [127:0] hbm_rsp_data;
  logic [63:0]  out_data;
  logic [7:0]   out_keep;
  logic         out_valid;
  logic         out_ready;
  logic         err_len;
  logic [31:0]  bytes_out;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
  } beat_t;

  beat_t       exp_beats[$];
  beat_t       obs_beats[$];
  logic [31:0] exp_addrs[$];
  logic [31:0] obs_addrs[$];
  logic [31:0] pend[$];

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_bytes = 32'd0;
  int          stall_viol = 0;
  bit          rsp_hold = 1'b0;
  bit          ready_toggle = 1'b0;
  int          manual_req = 0;
  int          manual_done = 0;
  int          rsp_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;

  dict_expander dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_is_match (tok_is_match),
    .tok_id       (tok_id),
    .tok_len      (tok_len),
    .tok_literal  (tok_literal),
    .hbm_rd_valid (hbm_rd_valid),
    .hbm_rd_addr  (hbm_rd_addr),
    .hbm_rd_rdy   (hbm_rd_rdy),
    .hbm_rsp_valid(hbm_rsp_valid),
    .hbm_rsp_data (hbm_rsp_data),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_len      (err_len),
    .bytes_out    (bytes_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hC3A5_0F1E, a + 32'h1357_9BDF, ~a,
            {a[7:0] ^ 8'h5A, a[15:8], a[23:16] ^ 8'hE7, a[31:24] + 8'h3C}};
  endfunction

  // Monitor: anything valid&ready at the negedge is taken at the following posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) obs_beats.push_back('{data: out_data, keep: out_keep});
      if (hbm_rd_valid && hbm_rd_rdy) begin
        obs_addrs.push_back(hbm_rd_addr);
        pend.push_back(hbm_rd_addr);
      end
      if (prev_stall && (!out_valid || out_data !== prev_data || out_keep !== prev_keep))
        stall_viol++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = ready_toggle ? ~out_ready : 1'b1;
    end
  end

  // HBM model: answers each read a few cycles later; manual pulses inject unsolicited data.
  initial begin
    hbm_rsp_valid = 1'b0;
    hbm_rsp_data  = 128'd0;
    forever begin
      @(posedge clk); #1;
      hbm_rsp_valid = 1'b0;
      if (manual_req != manual_done) begin
        hbm_rsp_valid = 1'b1;
        hbm_rsp_data  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        manual_done++;
      end else if (!rsp_hold && pend.size() > 0) begin
        if (rsp_cnt >= 2) begin
          hbm_rsp_valid = 1'b1;
          hbm_rsp_data  = mem_word(pend.pop_front());
          rsp_cnt = 0;
        end else begin
          rsp_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_literal(input logic [7:0] len, input logic [63:0] lit);
    exp_beats.push_back('{data: lit, keep: 8'((16'd1 << len) - 16'd1)});
    exp_bytes += 32'(len);
  endtask

  task automatic push_match(input logic [31:0] id, input logic [7:0] len);
    logic [31:0]  base;
    logic [127:0] word;
    int           rem;
    int           n;
    base = {6'b0, id[23:0], 2'b00};
    rem  = len;
    for (int b = 0; rem > 0; b++) begin
      word = mem_word(base + 32'(b / 2));
      if (b % 2 == 0) exp_addrs.push_back(base + 32'(b / 2));
      n = (rem > 8) ? 8 : rem;
      exp_beats.push_back('{data: (b % 2 == 1) ? word[127:64] : word[63:0],
                            keep: 8'((16'd1 << n) - 16'd1)});
      exp_bytes += 32'(n);
      rem -= n;
    end
  endtask

  task automatic send_token(input bit m, input logic [31:0] id, input logic [7:0] len,
                            input logic [63:0] lit);
    int n;
    tok_valid    = 1'b1;
    tok_is_match = m;
    tok_id       = id;
    tok_len      = len;
    tok_literal  = lit;
    n = 0;
    while (!tok_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    if (!tok_ready) begin
      mismatched++;
      $display("[TB] FAIL tok_accept: tok_ready=%0b, required 1 within 500 cycles", tok_ready);
    end
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (!tok_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    if (!tok_ready) begin
      mismatched++;
      $display("[TB] FAIL %s_idle: tok_ready=%0b, required 1 within 2000 cycles", name, tok_ready);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if ({out_valid, hbm_rd_valid, tok_ready, err_len} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: valid/rd/ready/err=%b, required 0000",
               {out_valid, hbm_rd_valid, tok_ready, err_len});
    end
    compared++;
    if (bytes_out !== 32'd0 || hbm_rd_addr !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counts: bytes_out=%0d addr=%h, required 0 0", bytes_out, hbm_rd_addr);
    end
    compared++;
    if (out_data !== 64'd0 || out_keep !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: data=%h keep=%h, required 0 0", out_data, out_keep);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    compared++;
    if (tok_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_release_ready: tok_ready=%b, required 1", tok_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_literal();
    beat_t e, o;
    push_literal(8'd3, 64'h0000_0000_00AA_BBCC);
    send_token(1'b0, 32'd0, 8'd3, 64'h0000_0000_00AA_BBCC);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL lit_latency: out_valid=%b one cycle after accept, required 1", out_valid);
    end
    wait_idle("lit");
    compared++;
    if (obs_beats.size() != exp_beats.size()) begin
      mismatched++;
      $display("[TB] FAIL lit_beat_count: got %0d, required %0d", obs_beats.size(), exp_beats.size());
    end
    while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
      e = exp_beats.pop_front();
      o = obs_beats.pop_front();
      compared++;
      if (o.data !== e.data || o.keep !== e.keep) begin
        mismatched++;
        $display("[TB] FAIL lit_beat: data=%h keep=%h, required %h %h", o.data, o.keep, e.data, e.keep);
      end
    end
    compared++;
    if (bytes_out !== exp_bytes) begin
      mismatched++;
      $display("[TB] FAIL lit_bytes_out: got %0d, required %0d", bytes_out, exp_bytes);
    end
    exp_beats.delete();
    obs_beats.delete();
  endtask

  task automatic test_match(input string name, input logic [31:0] id, input logic [7:0] len,
                            input bit toggle);
    beat_t       e, o;
    logic [31:0] ea, oa;
    stall_viol = 0;
    ready_toggle = toggle;
    push_match(id, len);
    send_token(1'b1, id, len, 64'd0);
    compared++;
    if (hbm_rd_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s_latency: hbm_rd_valid=%b one cycle after accept, required 1", name, hbm_rd_valid);
    end
    wait_idle(name);
    ready_toggle = 1'b0;
    compared++;
    if (obs_addrs.size() != exp_addrs.size() || obs_beats.size() != exp_beats.size()) begin
      mismatched++;
      $display("[TB] FAIL %s_counts: reads=%0d beats=%0d, required %0d %0d", name,
               obs_addrs.size(), obs_beats.size(), exp_addrs.size(), exp_beats.size());
    end
    while (exp_addrs.size() > 0 && obs_addrs.size() > 0) begin
      ea = exp_addrs.pop_front();
      oa = obs_addrs.pop_front();
      compared++;
      if (oa !== ea) begin
        mismatched++;
        $display("[TB] FAIL %s_addr: got %h, required %h", name, oa, ea);
      end
    end
    while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
      e = exp_beats.pop_front();
      o = obs_beats.pop_front();
      compared++;
      if (o.data !== e.data || o.keep !== e.keep) begin
        mismatched++;
        $display("[TB] FAIL %s_beat: data=%h keep=%h, required %h %h", name, o.data, o.keep, e.data, e.keep);
      end
    end
    compared++;
    if (stall_viol != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_stall_stable: %0d changes under stall, required 0", name, stall_viol);
    end
    compared++;
    if (bytes_out !== exp_bytes) begin
      mismatched++;
      $display("[TB] FAIL %s_bytes_out: got %0d, required %0d", name, bytes_out, exp_bytes);
    end
    exp_addrs.delete(); obs_addrs.delete();
    exp_beats.delete(); obs_beats.delete();
  endtask

  task automatic test_back_to_back();
    beat_t       e, o;
    logic [31:0] ea, oa;
    push_literal(8'd8, 64'h0102_0304_0506_0708);
    send_token(1'b0, 32'd0, 8'd8, 64'h0102_0304_0506_0708);
    push_match(32'hAB12_3456, 8'd9);
    send_token(1'b1, 32'hAB12_3456, 8'd9, 64'd0);
    push_literal(8'd1, 64'h1122_3344_5566_7788);
    send_token(1'b0, 32'd0, 8'd1, 64'h1122_3344_5566_7788);
    wait_idle("b2b");
    compared++;
    if (obs_beats.size() != exp_beats.size() || obs_addrs.size() != exp_addrs.size()) begin
      mismatched++;
      $display("[TB] FAIL b2b_counts: beats=%0d reads=%0d, required %0d %0d",
               obs_beats.size(), obs_addrs.size(), exp_beats.size(), exp_addrs.size());
    end
    while (exp_addrs.size() > 0 && obs_addrs.size() > 0) begin
      ea = exp_addrs.pop_front();
      oa = obs_addrs.pop_front();
      compared++;
      if (oa !== ea) begin
        mismatched++;
        $display("[TB] FAIL b2b_addr: got %h, required %h", oa, ea);
      end
    end
    while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
      e = exp_beats.pop_front();
      o = obs_beats.pop_front();
      compared++;
      if (o.data !== e.data || o.keep !== e.keep) begin
        mismatched++;
        $display("[TB] FAIL b2b_beat: data=%h keep=%h, required %h %h", o.data, o.keep, e.data, e.keep);
      end
    end
    compared++;
    if (bytes_out !== exp_bytes) begin
      mismatched++;
      $display("[TB] FAIL b2b_bytes_out: got %0d, required %0d", bytes_out, exp_bytes);
    end
    exp_addrs.delete(); obs_addrs.delete();
    exp_beats.delete(); obs_beats.delete();
  endtask

  task automatic test_idle_pulse();
    manual_req++;
    repeat (6) @(posedge clk);
    #1;
    compared++;
    if (obs_beats.size() != 0 || out_valid !== 1'b0 || tok_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL idle_rsp_ignored: beats=%0d out_valid=%b tok_ready=%b, required 0 0 1",
               obs_beats.size(), out_valid, tok_ready);
    end
    obs_beats.delete();
  endtask

  task automatic test_illegal_len();
    send_token(1'b1, 32'h0000_0009, 8'd65, 64'd0);
    send_token(1'b0, 32'd0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (8) @(posedge clk);
    #1;
    compared++;
    if (err_len !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL illegal_err_len: got %b, required 1", err_len);
    end
    compared++;
    if (obs_beats.size() != 0 || obs_addrs.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL illegal_no_traffic: beats=%0d reads=%0d, required 0 0",
               obs_beats.size(), obs_addrs.size());
    end
    compared++;
    if (bytes_out !== exp_bytes || tok_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL illegal_state: bytes_out=%0d tok_ready=%b, required %0d 1",
               bytes_out, tok_ready, exp_bytes);
    end
    obs_beats.delete();
    obs_addrs.delete();
  endtask

  task automatic test_reset_in_wait();
    int n;
    rsp_hold = 1'b1;
    push_match(32'h0000_0007, 8'd16);
    send_token(1'b1, 32'h0000_0007, 8'd16, 64'd0);
    n = 0;
    while (obs_addrs.size() == 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (obs_addrs.size() != 1 || (obs_addrs.size() > 0 && obs_addrs[0] !== 32'h0000_001C)) begin
      mismatched++;
      $display("[TB] FAIL rstwait_read: reads=%0d, required one read to 0000001c", obs_addrs.size());
    end
    compared++;
    if (hbm_rd_valid !== 1'b0 || out_valid !== 1'b0 || tok_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rstwait_waiting: rd=%b valid=%b ready=%b, required 0 0 0",
               hbm_rd_valid, out_valid, tok_ready);
    end
    rst_n = 1'b0;
    #2;
    compared++;
    if ({tok_ready, out_valid, hbm_rd_valid, err_len} !== 4'b0000 || bytes_out !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL rstwait_in_reset: ready/valid/rd/err=%b bytes_out=%0d, required 0000 0",
               {tok_ready, out_valid, hbm_rd_valid, err_len}, bytes_out);
    end
    pend.delete();
    exp_beats.delete(); obs_beats.delete();
    exp_addrs.delete(); obs_addrs.delete();
    exp_bytes = 32'd0;
    rsp_hold = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    compared++;
    if (tok_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstwait_release_ready: tok_ready=%b, required 1", tok_ready);
    end
    manual_req++;
    repeat (6) @(posedge clk);
    #1;
    compared++;
    if (obs_beats.size() != 0 || out_valid !== 1'b0 || bytes_out !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL rstwait_late_rsp: beats=%0d out_valid=%b bytes_out=%0d, required 0 0 0",
               obs_beats.size(), out_valid, bytes_out);
    end
    compared++;
    if (tok_ready !== 1'b1 || obs_addrs.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL rstwait_idle: tok_ready=%b reads=%0d, required 1 0", tok_ready, obs_addrs.size());
    end
  endtask

  initial begin
    test_reset();
    test_literal();
    test_match("match20", 32'h0000_0005, 8'd20, 1'b0);
    test_match("match64", 32'h0012_3400, 8'd64, 1'b1);
    test_match("match1", 32'hFF00_0001, 8'd1, 1'b0);
    test_back_to_back();
    test_idle_pulse();
    test_illegal_len();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
